delay_line: RTL and testbench
=============================

Name: delay_line

Overview:
- Parametrised, multi-channel, clock-enabled delay line; successor to the fixed-depth shift register utility.
- Delay is selected at runtime, from 1 to MAX_DELAY enabled cycles.
- A valid bit is carried alongside the data, and primed/flush tracking guards against stale data after reset or a delay change.
- Used in datapath alignment, e.g. matching pipeline latency between sample streams and control/strobe paths.

Parameters:
- WIDTH, 16, bits per channel.
- CHANNELS, 1, number of parallel channels; all channels share the delay, enable and valid.
- MAX_DELAY, 16, number of storage stages; must be >= 2 (elaboration error otherwise).
- RESET_DELAY, MAX_DELAY, effective delay after reset; must be in 1..MAX_DELAY.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  clock enable; the line shifts only when en=1.
- flush  in  1  clears all valid bits and the fill counter; data contents are kept.
- delay_ld  in  1  load strobe for delay.
- delay  in  DLY_W  requested delay; DLY_W = clog2(MAX_DELAY+1).
- data_in  in  CHANNELS*WIDTH  channel 0 occupies the LSBs.
- valid_in  in  1  qualifies data_in.
- data_out  out  CHANNELS*WIDTH  delayed data.
- valid_out  out  1  delayed valid, gated by primed.
- primed  out  1  line has filled to the current delay since the last rst/flush/delay load.
- delay_cur  out  DLY_W  effective (clamped) delay register.
- delay_err  out  1  sticky flag: an out-of-range delay was loaded.

Behaviour:
- Reset (rst=1 at a clock edge) overrides everything and sets:
  - all stage data and valid bits to 0;
  - delay_cur to RESET_DELAY, fill counter to 0, delay_err to 0.
- Resulting outputs after reset: data_out=0, valid_out=0, primed=0 (primed=1 only if RESET_DELAY=0, which is illegal).
- Storage: MAX_DELAY stages, each holding CHANNELS*WIDTH data bits plus 1 valid bit.
- Shift when en=1: stage[0] <= {valid_in, data_in}; stage[i] <= stage[i-1]. When en=0 all stages hold.
- Output tap:
  - data_out = stage[delay_cur-1] data; combinational mux from registers, no extra register.
  - Latency: a sample presented with en=1 at edge k appears on data_out after delay_cur enabled edges, counting edge k. With en tied high, data_in at cycle k appears at cycle k+delay_cur.
- valid_out = stage[delay_cur-1].valid AND primed. data_out is not gated.
- Delay load (delay_ld=1), effective from the next cycle:
  - delay=0 loads 1 and sets delay_err.
  - delay>MAX_DELAY loads MAX_DELAY and sets delay_err.
  - Any in-range value loads as-is.
  - delay_err is cleared only by rst.
- Fill counter (0..MAX_DELAY):
  - Increments on each en=1 cycle and saturates at delay_cur.
  - primed = (count >= delay_cur).
  - On delay_ld, count is set to 1 if en=1 in the same cycle, otherwise 0. This applies even if the new delay equals the old one.
- Flush (flush=1):
  - Clears all stage valid bits and the count.
  - If en=1 in the same cycle, stage data still shifts and stage[0].valid <= valid_in; the count becomes 1.
  - Flush and delay_ld together: both take effect; the count follows the delay_ld rule.
- Priority: rst > flush/delay_ld > en.
- Delay decreases: primed may remain deasserted although older valid data sits in deeper stages; this is intended (conservative).
- Boundaries:
  - delay_cur=1: data_out = stage[0], one cycle of latency.
  - delay_cur=MAX_DELAY: last stage is tapped.
  - Fill counter saturates and never wraps.

Decomposition:
- Shared util package/header: DLY_W as a clog2-derived constant, a clamp function for the delay range, and the parameter legality checks.
- One sub-module, delay_tap_mux: a purely combinational, parametrised selector of one of MAX_DELAY stage words, reusable by other taps.
- Storage, fill counter, delay register and flags stay in delay_line.

Test Plan:
- Reset + fill: WIDTH=8, CHANNELS=2, MAX_DELAY=16, RESET_DELAY=16, en=1, ramp data_in 0x0101,0x0202,… with valid_in=1 -> valid_out=0 for cycles 1..15; at cycle 16 data_out=0x0101, valid_out=1, primed=1.
- Runtime delay: after priming, delay_ld with delay=3 -> primed drops next cycle, reasserts 3 enabled cycles later; then data_out equals data_in from 3 cycles earlier.
- Clamp/error: load delay=0 -> delay_cur=1, delay_err=1. Then load delay=20 -> delay_cur=16, delay_err stays 1. Then rst -> delay_err=0, delay_cur=16.
- Enable gaps: delay=4, en pattern 1,0,0,1,1,1 with samples A..D on the enabled cycles -> A on data_out only after the 4th enabled edge; outputs hold during en=0.
- Flush mid-stream: delay=5, primed, flush=1 with en=1 -> valid_out=0 and primed=0 next cycle; primed returns after 5 enabled cycles, with valid_out tracking valid_in history.
- Reset mid-operation: assert rst during streaming with delay_cur=3 -> next cycle data_out=0, valid_out=0, delay_cur=RESET_DELAY, count=0.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared constants and helpers for the runtime-selectable delay line.
package delay_line_pkg;

    // Width of a field able to hold 0..max_delay.
    function automatic int dly_width(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    // Map any requested delay into the legal 1..max_delay range.
    function automatic int clamp_delay(input int req, input int max_delay);
        if (req < 1) begin
            return 1;
        end else if (req > max_delay) begin
            return max_delay;
        end
        return req;
    endfunction

    // True when a requested delay needs no clamping.
    function automatic bit delay_in_range(input int req, input int max_delay);
        return (req >= 1) && (req <= max_delay);
    endfunction

    // Parameter legality: at least two stages, reset delay inside the range.
    function automatic bit params_legal(input int max_delay, input int reset_delay);
        return (max_delay >= 2) && (reset_delay >= 1) && (reset_delay <= max_delay);
    endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// Combinational selector of one word out of N packed stage words (word 0 in the LSBs).
module delay_tap_mux #(
    parameter int W     = 16,
    parameter int N     = 16,
    parameter int SEL_W = $clog2(N + 1)
) (
    input  logic [N*W-1:0]   words,
    input  logic [SEL_W-1:0] sel,
    output logic [W-1:0]     word
);

    // Pick words[sel]; an out-of-range select yields zero.
    always_comb begin
        word = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                word = words[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/delay_line.sv
// Multi-channel, clock-enabled delay line with runtime delay selection and
// primed tracking so stale stage contents are never reported as valid.
//
// Stream semantics: valid_in qualifies data_in on every enabled cycle; there is
// no backpressure. valid_out qualifies data_out and is only asserted once the
// line has refilled to the current delay since the last rst, flush or delay load.
module delay_line
    import delay_line_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 1,
    parameter int MAX_DELAY   = 16,
    parameter int RESET_DELAY = MAX_DELAY,
    localparam int DLY_W      = dly_width(MAX_DELAY),
    localparam int DW         = CHANNELS * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             delay_ld,
    input  logic [DLY_W-1:0] delay,
    input  logic [DW-1:0]    data_in,
    input  logic             valid_in,
    output logic [DW-1:0]    data_out,
    output logic             valid_out,
    output logic             primed,
    output logic [DLY_W-1:0] delay_cur,
    output logic             delay_err
);

    if (!params_legal(MAX_DELAY, RESET_DELAY)) begin : g_bad_params
        $error("delay_line: need MAX_DELAY >= 2 and 1 <= RESET_DELAY <= MAX_DELAY");
    end

    logic [DW-1:0]        stage_data [MAX_DELAY];
    logic [MAX_DELAY-1:0] stage_valid;
    logic [DLY_W-1:0]     fill_cnt;
    logic [DLY_W-1:0]     delay_clamped;
    logic                 delay_bad;
    logic [DLY_W-1:0]     tap_sel;
    logic [MAX_DELAY*DW-1:0] stage_flat;
    logic                 tap_valid;

    assign delay_clamped = DLY_W'(clamp_delay(int'(delay), MAX_DELAY));
    assign delay_bad     = !delay_in_range(int'(delay), MAX_DELAY);
    assign tap_sel       = delay_cur - 1'b1;
    assign primed        = (fill_cnt >= delay_cur);
    assign valid_out     = tap_valid & primed;

    for (genvar g = 0; g < MAX_DELAY; g++) begin : g_flat
        assign stage_flat[g*DW +: DW] = stage_data[g];
    end

    // Data stages: shift on enable, contents survive flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                stage_data[i] <= '0;
            end
        end else if (en) begin
            stage_data[0] <= data_in;
            for (int i = 1; i < MAX_DELAY; i++) begin
                stage_data[i] <= stage_data[i-1];
            end
        end
    end

    // Valid stages: shift on enable; flush wipes everything except the sample entering now.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid <= '0;
        end else if (flush) begin
            stage_valid <= en ? {{(MAX_DELAY-1){1'b0}}, valid_in} : '0;
        end else if (en) begin
            stage_valid <= {stage_valid[MAX_DELAY-2:0], valid_in};
        end
    end

    // Delay register and sticky range-error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            delay_cur <= DLY_W'(RESET_DELAY);
            delay_err <= 1'b0;
        end else if (delay_ld) begin
            delay_cur <= delay_clamped;
            if (delay_bad) begin
                delay_err <= 1'b1;
            end
        end
    end

    // Fill counter: restarts on flush or delay load, saturates at the current delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= '0;
        end else if (delay_ld || flush) begin
            fill_cnt <= en ? DLY_W'(1) : '0;
        end else if (en && (fill_cnt < delay_cur)) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    delay_tap_mux #(.W(DW), .N(MAX_DELAY), .SEL_W(DLY_W)) u_data_tap (
        .words (stage_flat),
        .sel   (tap_sel),
        .word  (data_out)
    );

    delay_tap_mux #(.W(1), .N(MAX_DELAY), .SEL_W(DLY_W)) u_valid_tap (
        .words (stage_valid),
        .sel   (tap_sel),
        .word  (tap_valid)
    );

endmodule

// File: tb/tb_delay_line.sv
// Bench for delay_line: a history-queue model of enabled samples checked every
// cycle, plus literal expectations at the points of interest.
module tb_delay_line;

    localparam int WIDTH       = 8;
    localparam int CHANNELS    = 2;
    localparam int MAX_DELAY   = 16;
    localparam int RESET_DELAY = 16;
    localparam int DW          = WIDTH * CHANNELS;
    localparam int DLY_W       = 5;

    // ---------------- clock / reset / signals ----------------
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic             delay_ld = 1'b0;
    logic [DLY_W-1:0] delay = '0;
    logic [DW-1:0]    data_in = '0;
    logic             valid_in = 1'b0;
    logic [DW-1:0]    data_out;
    logic             valid_out;
    logic             primed;
    logic [DLY_W-1:0] delay_cur;
    logic             delay_err;

    always #5 clk = ~clk;

    delay_line #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_DELAY(MAX_DELAY), .RESET_DELAY(RESET_DELAY)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .delay_ld(delay_ld), .delay(delay),
        .data_in(data_in), .valid_in(valid_in), .data_out(data_out), .valid_out(valid_out),
        .primed(primed), .delay_cur(delay_cur), .delay_err(delay_err)
    );

    // ---------------- model ----------------
    // hist[0] is the most recently enabled sample; {valid, data}.
    logic [DW:0] hist[$];
    int          m_delay = RESET_DELAY;
    bit          m_err = 1'b0;
    int          m_fill = 0;
    bit          model_ok = 1'b0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit f, input bit l,
                              input int d, input logic [DW-1:0] di, input bit vi);
        if (r) begin
            hist.delete();
            for (int i = 0; i < MAX_DELAY; i++) hist.push_back('0);
            m_delay = RESET_DELAY;
            m_err   = 1'b0;
            m_fill  = 0;
            return;
        end
        if (e) begin
            hist.push_front({vi, di});
            void'(hist.pop_back());
        end
        if (f) begin
            for (int i = (e ? 1 : 0); i < MAX_DELAY; i++) hist[i][DW] = 1'b0;
        end
        if (l) begin
            if (d < 1) begin
                m_delay = 1; m_err = 1'b1;
            end else if (d > MAX_DELAY) begin
                m_delay = MAX_DELAY; m_err = 1'b1;
            end else begin
                m_delay = d;
            end
        end
        if (l || f) m_fill = e ? 1 : 0;
        else if (e) m_fill++;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("data_out",  32'(data_out),  32'(hist[m_delay-1][DW-1:0]));
            chk("valid_out", 32'(valid_out), 32'(hist[m_delay-1][DW] && (m_fill >= m_delay)));
            chk("primed",    32'(primed),    32'(m_fill >= m_delay));
            chk("delay_cur", 32'(delay_cur), 32'(m_delay));
            chk("delay_err", 32'(delay_err), 32'(m_err));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input bit r, input bit e, input bit f, input bit l,
                       input int d, input logic [DW-1:0] di, input bit vi);
        rst = r; en = e; flush = f; delay_ld = l;
        delay = DLY_W'(d); data_in = di; valid_in = vi;
        @(posedge clk);
        model_step(r, e, f, l, d, di, vi);
        if (r) model_ok = 1'b1;
        #1;
    endtask

    task automatic do_reset();   cyc(1, 0, 0, 0, 0, '0, 0); endtask
    task automatic idle();       cyc(0, 0, 0, 0, 0, '0, 0); endtask
    task automatic push(input logic [DW-1:0] di, input bit vi); cyc(0, 1, 0, 0, 0, di, vi); endtask
    task automatic load(input int d, input bit e); cyc(0, e, 0, 1, d, 16'h5A5A, 1); endtask

    // ---------------- directed sequence ----------------
    initial begin
        do_reset();
        chk("rst_data",    32'(data_out),  32'h0);
        chk("rst_valid",   32'(valid_out), 32'h0);
        chk("rst_primed",  32'(primed),    32'h0);
        chk("rst_delay",   32'(delay_cur), 32'd16);

        // Fill at the reset delay with a ramp.
        for (int k = 1; k <= 16; k++) begin
            push(DW'(16'h0101 * k), 1'b1);
            if (k == 15) chk("fill_k15_valid", 32'(valid_out), 32'h0);
        end
        chk("fill_k16_data",   32'(data_out),  32'h0101);
        chk("fill_k16_valid",  32'(valid_out), 32'h1);
        chk("fill_k16_primed", 32'(primed),    32'h1);

        // Runtime delay change to 3.
        load(3, 1'b0);
        chk("ld3_primed", 32'(primed),    32'h0);
        chk("ld3_delay",  32'(delay_cur), 32'd3);
        push(16'hA1A1, 1'b1);
        push(16'hB2B2, 1'b1);
        chk("ld3_not_yet", 32'(primed), 32'h0);
        push(16'hC3C3, 1'b1);
        chk("ld3_primed_back", 32'(primed),   32'h1);
        chk("ld3_data",        32'(data_out), 32'hA1A1);

        // Clamp and sticky error.
        load(0, 1'b0);
        chk("clamp0_delay", 32'(delay_cur), 32'd1);
        chk("clamp0_err",   32'(delay_err), 32'h1);
        load(20, 1'b0);
        chk("clamp20_delay", 32'(delay_cur), 32'd16);
        chk("clamp20_err",   32'(delay_err), 32'h1);
        do_reset();
        chk("rst_err_clr",   32'(delay_err), 32'h0);
        chk("rst_delay16",   32'(delay_cur), 32'd16);

        // Enable gaps at delay 4: A, gap, gap, B, C, D.
        load(4, 1'b0);
        push(16'h0A0A, 1'b1);
        idle();
        idle();
        push(16'h0B0B, 1'b1);
        push(16'h0C0C, 1'b1);
        chk("gap_before_A", 32'(data_out), 32'h0);
        push(16'h0D0D, 1'b1);
        chk("gap_A_out",    32'(data_out),  32'h0A0A);
        chk("gap_A_valid",  32'(valid_out), 32'h1);
        idle();
        chk("gap_hold",     32'(data_out),  32'h0A0A);

        // Flush mid-stream at delay 5.
        load(5, 1'b0);
        for (int k = 0; k < 5; k++) push(DW'(16'h1100 + k), 1'b1);
        chk("fl_primed_pre", 32'(primed), 32'h1);
        cyc(0, 1, 1, 0, 0, 16'h0E0E, 1'b1);
        chk("fl_valid",  32'(valid_out), 32'h0);
        chk("fl_primed", 32'(primed),    32'h0);
        push(16'h2001, 1'b0);
        push(16'h2002, 1'b1);
        push(16'h2003, 1'b0);
        push(16'h2004, 1'b1);
        chk("fl_primed_back", 32'(primed),    32'h1);
        chk("fl_E_data",      32'(data_out),  32'h0E0E);
        chk("fl_E_valid",     32'(valid_out), 32'h1);
        push(16'h2005, 1'b1);
        chk("fl_gap_valid",   32'(valid_out), 32'h0);
        // Flush without enable, then flush together with a load.
        cyc(0, 0, 1, 0, 0, '0, 0);
        cyc(0, 1, 1, 1, 2, 16'h3030, 1'b1);
        push(16'h3131, 1'b1);
        chk("fl_ld_data", 32'(data_out), 32'h3030);

        // Delay 1 loaded with enable: primed and tapping stage 0 right away.
        cyc(0, 1, 0, 1, 1, 16'h4444, 1'b1);
        chk("d1_data",  32'(data_out),  32'h4444);
        chk("d1_valid", 32'(valid_out), 32'h1);
        for (int k = 0; k < 6; k++) begin
            if (k % 3 == 2) idle();
            else push(DW'($urandom_range(0, 16'hFFFF)), 1'(k % 2));
        end

        // Reset in the middle of streaming at delay 3.
        load(3, 1'b1);
        for (int k = 0; k < 4; k++) push(DW'(16'h5500 + k), 1'b1);
        cyc(1, 1, 0, 0, 0, 16'h6666, 1'b1);
        chk("mid_rst_data",   32'(data_out),  32'h0);
        chk("mid_rst_valid",  32'(valid_out), 32'h0);
        chk("mid_rst_delay",  32'(delay_cur), 32'd16);
        chk("mid_rst_primed", 32'(primed),    32'h0);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
